avg_window_tx: RTL and testbench
================================

Name: avg_window_tx

Overview:
- Transmit side of the window-average stream: turns a raw pixel stream into sliding-window sums.
- Emits `dout_data`/`dout_valid` in the format the average capture stage consumes: width PIXEL_WIDTH+LOG2_WIN, 12 bits at default.
- Sits between the line/pixel source and the capture stage in the max/min/average filter path.
- Keeps a per-line sliding window of 2^LOG2_WIN pixels and updates the sum with a running add/subtract.

Parameters:
- PIXEL_WIDTH, 8, bits per input pixel.
- LOG2_WIN, 4, log2 of window length; WIN = 2^LOG2_WIN = 16.

Ports:
- clk  in  1  single clock, rising edge.
- arstn  in  1  asynchronous, active-low reset.
- din_data  in  PIXEL_WIDTH  input pixel.
- din_valid  in  1  pixel valid.
- din_last  in  1  qualifies the last pixel of a line; sampled only on accept.
- din_ready  out  1  block can accept; a pixel is accepted when din_valid & din_ready.
- dout_data  out  PIXEL_WIDTH+LOG2_WIN  window sum (or mean, see Optional Feature).
- dout_valid  out  1  single-cycle qualifier per output sample; no backpressure.
- dout_last  out  1  asserted with the final output sample of a line.

Behaviour:
- Reset (async, arstn low): state=FILL, count=0, window shift register cleared, sum=0, din_ready=0, dout_valid=0, dout_last=0, dout_data=0.
- din_ready rises on the first clock after reset release.
- Reset mid-line discards all partial window and line state; no output is produced for that line.
- States:
  - FILL: window not yet full.
  - RUN: window full.
  - CLEAR: one-cycle flush between lines.
- On every accept in FILL or RUN:
  - sr shifts in din_data.
  - sum_next = sum + din_data - sr[WIN-1]. The register is cleared on line start, so FILL subtracts 0.
- Sum arithmetic is unsigned in PIXEL_WIDTH+LOG2_WIN bits and never overflows; maximum is WIN*(2^PIXEL_WIDTH-1).
- Counter:
  - count increments in FILL, saturating at WIN.
  - The accept that brings count to WIN moves FILL->RUN.
- Output latency is 1 cycle. dout_valid=1 in the cycle after an accept that leaves the window full, i.e. the WIN-th and every later accept of the line. dout_data = sum_next registered.
- No accept means dout_valid=0 next cycle; dout_data holds its last value.
- Accept with din_last=1:
  - If the window is full after this pixel, that output carries dout_last=1.
  - If the line is shorter than WIN, no output and no dout_last.
  - Either way, state moves to CLEAR.
- CLEAR (1 cycle): din_ready=0; sr, sum and count are cleared; the next state is FILL.
- din_ready=1 in FILL and RUN; it is registered and derived from next state.
- din_last on a pixel that completes the window exactly (line length == WIN): one output with dout_last=1.
- din_data and din_last are ignored when not accepted.

Optional Feature:
- Macro: AVG_WINDOW_TX_MEAN_EN.
- Defined: dout_data = (sum_next + WIN/2) >> LOG2_WIN, zero-extended to PIXEL_WIDTH+LOG2_WIN bits (round-half-up). Timing and flags are unchanged. The rounded mean is clamped to 2^PIXEL_WIDTH-1; it cannot exceed this, but the clamp is kept.
- Undefined: the raw sum is output.

Decomposition:
- Shared package avg_pkg:
  - function clog2.
  - localparams WIN and SUM_WIDTH = PIXEL_WIDTH+LOG2_WIN.
  - state encoding constants ST_FILL, ST_RUN, ST_CLEAR.
- One natural sub-module: avg_window_sr. It is a WIN-deep PIXEL_WIDTH shift register with shift-enable and synchronous clear, and exposes the oldest tap.

Test Plan (PIXEL_WIDTH=8, LOG2_WIN=4):
- Constant 10, 20 pixels, last on 20th -> exactly 5 dout_valid pulses, each 160; dout_last on the 5th only; din_ready low 1 cycle after the last accept.
- Ramp 0..19 continuous -> outputs 120, 136, 152, 168, 184, each 1 cycle after accepting pixels 15..19. With MEAN_EN: 8, 9, 10, 11, 12 (120/16 = 7.5 rounds up to 8).
- 16 pixels of 255 with last on 16th -> single output 4080 with dout_last=1. With MEAN_EN: 255.
- Short line of 10 pixels with last -> no dout_valid, no dout_last. Next line of 16×1 -> output 16, proving the window was cleared.
- din_valid toggling every other cycle on a ramp -> same sums as the continuous run, outputs spaced 2 cycles apart.
- arstn pulsed low after 12 pixels of a line -> all outputs 0 immediately. Next line of 16×2 -> single output 32.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared types and constants for the sliding-window average transmit path.
// The optional rounded-mean output is selected with AVG_WINDOW_TX_MEAN_EN.
package avg_pkg;

    localparam int DEF_PIXEL_WIDTH = 8;
    localparam int DEF_LOG2_WIN    = 4;
    localparam int WIN             = 1 << DEF_LOG2_WIN;
    localparam int SUM_WIDTH       = DEF_PIXEL_WIDTH + DEF_LOG2_WIN;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/avg_window_sr.sv
// WIN-deep pixel shift register with shift enable and synchronous clear;
// the oldest tap feeds the subtract side of the running sum.
module avg_window_sr #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             shift_en,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] oldest
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else if (shift_en) begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign oldest = taps[DEPTH-1];

endmodule

// File: rtl/avg_window_tx.sv
// Per-line sliding-window sum over 2^LOG2_WIN pixels, one output per accept once full.
// Define AVG_WINDOW_TX_MEAN_EN to emit the round-half-up mean instead of the raw sum.
//
// state    | meaning
// ST_FILL  | window not yet full, no outputs
// ST_RUN   | window full, one output per accept
// ST_CLEAR | one-cycle flush between lines, din_ready low
module avg_window_tx
    import avg_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int LOG2_WIN    = DEF_LOG2_WIN
) (
    input  logic                            clk,
    input  logic                            arstn,
    input  logic [PIXEL_WIDTH-1:0]          din_data,
    input  logic                            din_valid,
    input  logic                            din_last,
    output logic                            din_ready,
    output logic [PIXEL_WIDTH+LOG2_WIN-1:0] dout_data,
    output logic                            dout_valid,
    output logic                            dout_last
);

    localparam int WIN_LEN = 1 << LOG2_WIN;
    localparam int SUM_W   = PIXEL_WIDTH + LOG2_WIN;
    localparam int CNT_W   = clog2(WIN_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIN_LEN);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIN_LEN - 1);

    state_t                 state, state_next;
    logic [CNT_W-1:0]       count;
    logic [SUM_W-1:0]       sum, sum_next, result;
    logic [PIXEL_WIDTH-1:0] oldest;
    logic                   ready, accept, full_after, flush;

    assign din_ready  = ready;
    assign accept     = din_valid & ready;
    assign flush      = (state == ST_CLEAR);
    // Window is full after this accept if it already was, or this is the WIN-th pixel.
    assign full_after = (count == CNT_FULL) || (count == CNT_PRE);
    assign sum_next   = sum + SUM_W'(din_data) - SUM_W'(oldest);

`ifdef AVG_WINDOW_TX_MEAN_EN
    localparam logic [SUM_W:0]   HALF    = (SUM_W+1)'(WIN_LEN / 2);
    localparam logic [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIXEL_WIDTH) - 1);
    logic [SUM_W:0] rounded;

    assign rounded = ({1'b0, sum_next} + HALF) >> LOG2_WIN;
    assign result  = (rounded > {1'b0, PIX_MAX}) ? PIX_MAX : rounded[SUM_W-1:0];
`else
    assign result = sum_next;
`endif

    avg_window_sr #(
        .WIDTH (PIXEL_WIDTH),
        .DEPTH (WIN_LEN)
    ) u_sr (
        .clk      (clk),
        .arstn    (arstn),
        .shift_en (accept),
        .clear    (flush),
        .din      (din_data),
        .oldest   (oldest)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_FILL: begin
                if (accept) begin
                    if (din_last)              state_next = ST_CLEAR;
                    else if (count == CNT_PRE) state_next = ST_RUN;
                end
            end
            ST_RUN:   if (accept && din_last) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_FILL;
            default:  state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state      <= ST_FILL;
            ready      <= 1'b0;
            count      <= '0;
            sum        <= '0;
            dout_data  <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            state      <= state_next;
            ready      <= (state_next != ST_CLEAR);
            dout_valid <= accept & full_after;
            dout_last  <= accept & full_after & din_last;
            if (accept && full_after) dout_data <= result;
            if (flush) begin
                count <= '0;
                sum   <= '0;
            end else if (accept) begin
                sum <= sum_next;
                if (count != CNT_FULL) count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avg_window_tx.sv
// Directed bench for avg_window_tx at PIXEL_WIDTH=8, LOG2_WIN=4; expectations switch
// to the rounded mean when AVG_WINDOW_TX_MEAN_EN is defined.
module tb_avg_window_tx;

    logic        clk;
    logic        arstn;
    logic [7:0]  din_data;
    logic        din_valid;
    logic        din_last;
    logic        din_ready;
    logic [11:0] dout_data;
    logic        dout_valid;
    logic        dout_last;

    int checks;
    int errors;
    int pulses;
    int lasts;
    logic        obs_v;
    logic        obs_l;
    logic [11:0] obs_d;

`ifdef AVG_WINDOW_TX_MEAN_EN
    localparam logic [11:0] EXP_CONST = 12'd10;
    localparam logic [11:0] EXP_FULL  = 12'd255;
    localparam logic [11:0] EXP_ONES  = 12'd1;
    localparam logic [11:0] EXP_TWOS  = 12'd2;
    logic [11:0] ramp_exp [5] = '{12'd8, 12'd9, 12'd10, 12'd11, 12'd12};
`else
    localparam logic [11:0] EXP_CONST = 12'd160;
    localparam logic [11:0] EXP_FULL  = 12'd4080;
    localparam logic [11:0] EXP_ONES  = 12'd16;
    localparam logic [11:0] EXP_TWOS  = 12'd32;
    logic [11:0] ramp_exp [5] = '{12'd120, 12'd136, 12'd152, 12'd168, 12'd184};
`endif

    avg_window_tx dut (
        .clk        (clk),
        .arstn      (arstn),
        .din_data   (din_data),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_last  (dout_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one pixel, waits (bounded) for ready, and captures the outputs one cycle after accept.
    task automatic push(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        din_data  = d;
        din_last  = l;
        din_valid = 1'b1;
        while (!din_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait got %b want 1", din_ready);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        din_last  = 1'b1;
        din_data  = 8'hAA;
        obs_v = dout_valid;
        obs_l = dout_last;
        obs_d = dout_data;
        if (dout_valid === 1'b1) pulses++;
        if (dout_last === 1'b1) lasts++;
    endtask

    task automatic test_reset;
        arstn     = 1'b0;
        din_valid = 1'b0;
        din_last  = 1'b0;
        din_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({din_ready, dout_valid, dout_last} !== 3'b000 || dout_data !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b v=%b l=%b d=%0d want all 0",
                     din_ready, dout_valid, dout_last, dout_data);
        end
        arstn = 1'b1;
        #1;
        checks++;
        if (din_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b want 0", din_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got %b want 1", din_ready);
        end
    endtask

    task automatic test_constant;
        pulses = 0;
        lasts  = 0;
        for (int i = 0; i < 20; i++) begin
            push(8'd10, i == 19);
            checks++;
            if (obs_v !== (i >= 15)) begin
                errors++;
                $display("FAIL const_valid[%0d] got %b want %b", i, obs_v, i >= 15);
            end
            if (i >= 15) begin
                checks++;
                if (obs_d !== EXP_CONST || obs_l !== (i == 19)) begin
                    errors++;
                    $display("FAIL const_out[%0d] got d=%0d l=%b want d=%0d l=%b",
                             i, obs_d, obs_l, EXP_CONST, i == 19);
                end
            end
        end
        checks++;
        if (din_ready !== 1'b0) begin
            errors++;
            $display("FAIL const_clear_ready got %b want 0", din_ready);
        end
        checks++;
        if (pulses != 5 || lasts != 1) begin
            errors++;
            $display("FAIL const_counts got pulses=%0d lasts=%0d want 5 1", pulses, lasts);
        end
    endtask

    task automatic run_ramp(input string name, input bit gapped);
        pulses = 0;
        lasts  = 0;
        for (int i = 0; i < 20; i++) begin
            push(8'(i), i == 19);
            if (i >= 15) begin
                checks++;
                if (obs_v !== 1'b1 || obs_d !== ramp_exp[i-15] || obs_l !== (i == 19)) begin
                    errors++;
                    $display("FAIL %s_out[%0d] got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                             name, i, obs_v, obs_d, obs_l, ramp_exp[i-15], i == 19);
                end
            end
            if (gapped) begin
                @(posedge clk); #1;
                checks++;
                if (dout_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_gap[%0d] got v=%b want 0", name, i, dout_valid);
                end
            end
        end
        checks++;
        if (pulses != 5 || lasts != 1) begin
            errors++;
            $display("FAIL %s_counts got pulses=%0d lasts=%0d want 5 1", name, pulses, lasts);
        end
    endtask

    task automatic test_ramp;
        run_ramp("ramp", 1'b0);
    endtask

    task automatic test_full_scale;
        pulses = 0;
        lasts  = 0;
        for (int i = 0; i < 16; i++) push(8'd255, i == 15);
        checks++;
        if (obs_v !== 1'b1 || obs_d !== EXP_FULL || obs_l !== 1'b1) begin
            errors++;
            $display("FAIL full_out got v=%b d=%0d l=%b want v=1 d=%0d l=1",
                     obs_v, obs_d, obs_l, EXP_FULL);
        end
        checks++;
        if (pulses != 1 || lasts != 1) begin
            errors++;
            $display("FAIL full_counts got pulses=%0d lasts=%0d want 1 1", pulses, lasts);
        end
    endtask

    task automatic test_short_line;
        pulses = 0;
        lasts  = 0;
        for (int i = 0; i < 10; i++) push(8'd200, i == 9);
        checks++;
        if (pulses != 0 || lasts != 0) begin
            errors++;
            $display("FAIL short_counts got pulses=%0d lasts=%0d want 0 0", pulses, lasts);
        end
        for (int i = 0; i < 16; i++) push(8'd1, i == 15);
        checks++;
        if (obs_v !== 1'b1 || obs_d !== EXP_ONES || obs_l !== 1'b1 || pulses != 1) begin
            errors++;
            $display("FAIL short_next got v=%b d=%0d l=%b pulses=%0d want v=1 d=%0d l=1 pulses=1",
                     obs_v, obs_d, obs_l, pulses, EXP_ONES);
        end
    endtask

    task automatic test_back_to_back;
        run_ramp("gapped", 1'b1);
    endtask

    task automatic test_reset_mid_line;
        for (int i = 0; i < 12; i++) push(8'd5, 1'b0);
        arstn = 1'b0;
        #1;
        checks++;
        if ({din_ready, dout_valid, dout_last} !== 3'b000 || dout_data !== 12'd0) begin
            errors++;
            $display("FAIL midreset_outputs got rdy=%b v=%b l=%b d=%0d want all 0",
                     din_ready, dout_valid, dout_last, dout_data);
        end
        @(posedge clk); #1;
        arstn = 1'b1;
        pulses = 0;
        lasts  = 0;
        for (int i = 0; i < 16; i++) push(8'd2, i == 15);
        checks++;
        if (obs_v !== 1'b1 || obs_d !== EXP_TWOS || obs_l !== 1'b1 || pulses != 1) begin
            errors++;
            $display("FAIL midreset_next got v=%b d=%0d l=%b pulses=%0d want v=1 d=%0d l=1 pulses=1",
                     obs_v, obs_d, obs_l, pulses, EXP_TWOS);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pulses = 0;
        lasts  = 0;
        test_reset;
        test_constant;
        test_ramp;
        test_full_scale;
        test_short_line;
        test_back_to_back;
        test_reset_mid_line;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
